// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Moore-style control FSM for a multi-cycle MIPS-subset datapath. It sequences
// fetch, decode, memory, ALU, branch, jump and trap states. It drives the
// datapath mux selects and write enables for each state.
//
// Parameters
//   EXT_OPS   1: ANDI / ORI / BNE are legal. 0: those opcodes trap.
//   WAIT_MEM  1: FETCH / MEMREAD / MEMWRITE stall until mem_ready.
//             0: memory is treated as always ready.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   op, funct              instruction fields [31:26] and [5:0]
//   zero                   ALU zero flag (used in BRANCH)
//   mem_ready              memory access completes this cycle
//   pc_en, ir_write        PC / IR write enables (combinational gating)
//   reg_write, mem_write   register file / memory write enables
//   iord                   memory address select (0 PC, 1 ALUOut)
//   alu_src_a              ALU A select (0 PC, 1 register A)
//   alu_src_b              ALU B select (00 reg, 01 const 4, 10 imm, 11 imm<<2)
//   reg_dst                destination register select (0 rt, 1 rd)
//   mem_to_reg             write-back source (0 ALUOut, 1 memory data)
//   imm_zext               zero-extend the immediate (logical immediates)
//   pc_src                 PC source (00 ALU, 01 ALUOut, 10 jump target)
//   alu_ctl                ALU op (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   trap                   sticky illegal-instruction flag
//   state_dbg              current FSM state encoding, for observation
//
// Handshake: mem_ready is a single-cycle "done" strobe. It is sampled in
// FETCH, MEMREAD and MEMWRITE. A state that waits on it holds its outputs
// until mem_ready is 1 at a rising clk edge, and then advances.
// -----------------------------------------------------------------------------
module mc_controller #(
    parameter int EXT_OPS  = 1,
    parameter int WAIT_MEM = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       iord,
    output logic       alu_src_a,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       imm_zext,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctl,
    output logic       trap,
    output logic [3:0] state_dbg
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IEXEC    = 4'd9,
        S_IWB      = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Opcode class latched in DECODE. Later states use it instead of op, so
    // op may change freely once decode is done.
    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_LW   = 3'd1,
        C_SW   = 3'd2,
        C_BEQ  = 3'd3,
        C_BNE  = 3'd4,
        C_ADDI = 3'd5,
        C_ANDI = 3'd6,
        C_ORI  = 3'd7
    } cls_t;

    state_t state;
    state_t nxt;
    cls_t   cls;
    cls_t   nxt_cls;

    logic       mem_rdy;
    logic       ext;
    logic       funct_ok;
    logic [2:0] funct_alu;

    // Registered-output next values, decoded from the state being entered
    logic       d_reg_write;
    logic       d_mem_write;
    logic       d_iord;
    logic       d_alu_src_a;
    logic       d_reg_dst;
    logic       d_mem_to_reg;
    logic       d_imm_zext;
    logic [1:0] d_alu_src_b;
    logic [1:0] d_pc_src;
    logic [2:0] d_alu_ctl;
    logic       d_trap;

    assign mem_rdy   = (WAIT_MEM != 0) ? mem_ready : 1'b1;
    assign ext       = (EXT_OPS != 0);
    assign state_dbg = state;

    // R-type funct legality and ALU mapping
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            F_ADD:   funct_alu = ALU_ADD;
            F_SUB:   funct_alu = ALU_SUB;
            F_AND:   funct_alu = ALU_AND;
            F_OR:    funct_alu = ALU_OR;
            F_SLT:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Next-state and class-latch logic
    always_comb begin
        nxt     = state;
        nxt_cls = cls;
        case (state)
            S_FETCH:    if (mem_rdy) nxt = S_DECODE;
            S_DECODE: begin
                nxt     = S_TRAP;
                nxt_cls = C_NONE;
                case (op)
                    OP_LW:    begin nxt = S_MEMADR; nxt_cls = C_LW;   end
                    OP_SW:    begin nxt = S_MEMADR; nxt_cls = C_SW;   end
                    OP_RTYPE: if (funct_ok) nxt = S_EXECUTE;
                    OP_BEQ:   begin nxt = S_BRANCH; nxt_cls = C_BEQ;  end
                    OP_BNE:   if (ext) begin nxt = S_BRANCH; nxt_cls = C_BNE; end
                    OP_ADDI:  begin nxt = S_IEXEC;  nxt_cls = C_ADDI; end
                    OP_ANDI:  if (ext) begin nxt = S_IEXEC; nxt_cls = C_ANDI; end
                    OP_ORI:   if (ext) begin nxt = S_IEXEC; nxt_cls = C_ORI;  end
                    OP_J:     nxt = S_JUMP;
                    default:  nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt = (cls == C_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_rdy) nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: if (mem_rdy) nxt = S_FETCH;
            S_EXECUTE:  nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BRANCH:   nxt = S_FETCH;
            S_IEXEC:    nxt = S_IWB;
            S_IWB:      nxt = S_FETCH;
            S_JUMP:     nxt = S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_FETCH;
        endcase
    end

    // Moore outputs for the state being entered. They are registered together
    // with the state, so each output is glitch-free for the whole cycle. The
    // EXECUTE ALU op comes from funct in DECODE. That is the only path into
    // EXECUTE.
    always_comb begin
        d_reg_write  = 1'b0;
        d_mem_write  = 1'b0;
        d_iord       = 1'b0;
        d_alu_src_a  = 1'b0;
        d_reg_dst    = 1'b0;
        d_mem_to_reg = 1'b0;
        d_imm_zext   = 1'b0;
        d_alu_src_b  = 2'b00;
        d_pc_src     = 2'b00;
        d_alu_ctl    = ALU_ADD;
        d_trap       = 1'b0;
        case (nxt)
            S_FETCH:    d_alu_src_b = 2'b01;
            S_DECODE:   d_alu_src_b = 2'b11;
            S_MEMADR: begin
                d_alu_src_a = 1'b1;
                d_alu_src_b = 2'b10;
            end
            S_MEMREAD:  d_iord = 1'b1;
            S_MEMWB: begin
                d_mem_to_reg = 1'b1;
                d_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                d_iord      = 1'b1;
                d_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                d_alu_src_a = 1'b1;
                d_alu_ctl   = funct_alu;
            end
            S_ALUWB: begin
                d_reg_dst   = 1'b1;
                d_reg_write = 1'b1;
            end
            S_BRANCH: begin
                d_alu_src_a = 1'b1;
                d_alu_ctl   = ALU_SUB;
                d_pc_src    = 2'b01;
            end
            S_IEXEC: begin
                d_alu_src_a = 1'b1;
                d_alu_src_b = 2'b10;
                if (nxt_cls == C_ANDI) begin
                    d_alu_ctl  = ALU_AND;
                    d_imm_zext = 1'b1;
                end else if (nxt_cls == C_ORI) begin
                    d_alu_ctl  = ALU_OR;
                    d_imm_zext = 1'b1;
                end
            end
            S_IWB:      d_reg_write = 1'b1;
            S_JUMP:     d_pc_src = 2'b10;
            S_TRAP:     d_trap = 1'b1;
            default:    d_alu_ctl = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            cls        <= C_NONE;
            reg_write  <= 1'b0;
            mem_write  <= 1'b0;
            iord       <= 1'b0;
            alu_src_a  <= 1'b0;
            reg_dst    <= 1'b0;
            mem_to_reg <= 1'b0;
            imm_zext   <= 1'b0;
            alu_src_b  <= 2'b01;
            pc_src     <= 2'b00;
            alu_ctl    <= ALU_ADD;
            trap       <= 1'b0;
        end else begin
            state      <= nxt;
            cls        <= nxt_cls;
            reg_write  <= d_reg_write;
            mem_write  <= d_mem_write;
            iord       <= d_iord;
            alu_src_a  <= d_alu_src_a;
            reg_dst    <= d_reg_dst;
            mem_to_reg <= d_mem_to_reg;
            imm_zext   <= d_imm_zext;
            alu_src_b  <= d_alu_src_b;
            pc_src     <= d_pc_src;
            alu_ctl    <= d_alu_ctl;
            trap       <= d_trap;
        end
    end

    // These enables react within the cycle to mem_ready and zero. They are
    // gated by rst_n so that no write fires while reset is held.
    assign ir_write = rst_n && (state == S_FETCH) && mem_rdy;
    assign pc_en    = rst_n && (((state == S_FETCH) && mem_rdy) ||
                                (state == S_JUMP) ||
                                ((state == S_BRANCH) && ((cls == C_BNE) ? !zero : zero)));

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTE  = 4'd6;
    localparam logic [3:0] ST_ALUWB    = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
    localparam logic [3:0] ST_IEXEC    = 4'd9;
    localparam logic [3:0] ST_IWB      = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_TRAP     = 4'd12;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en, ir_write, reg_write, mem_write, iord, alu_src_a;
    logic       reg_dst, mem_to_reg, imm_zext, trap;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctl;
    logic [3:0] state_dbg;

    logic       n_pc_en, n_ir_write, n_reg_write, n_mem_write, n_iord, n_alu_src_a;
    logic       n_reg_dst, n_mem_to_reg, n_imm_zext, n_trap;
    logic [1:0] n_alu_src_b, n_pc_src;
    logic [2:0] n_alu_ctl;
    logic [3:0] n_state_dbg;

    int total = 0;
    int bad   = 0;

    mc_controller #(.EXT_OPS(1), .WAIT_MEM(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
        .reg_write(reg_write), .mem_write(mem_write), .iord(iord),
        .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .imm_zext(imm_zext), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_ctl(alu_ctl), .trap(trap), .state_dbg(state_dbg)
    );

    mc_controller #(.EXT_OPS(0), .WAIT_MEM(1)) dut_noext (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(n_pc_en), .ir_write(n_ir_write),
        .reg_write(n_reg_write), .mem_write(n_mem_write), .iord(n_iord),
        .alu_src_a(n_alu_src_a), .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg),
        .imm_zext(n_imm_zext), .alu_src_b(n_alu_src_b), .pc_src(n_pc_src),
        .alu_ctl(n_alu_ctl), .trap(n_trap), .state_dbg(n_state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 2 time units past it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset, LW with mem_ready=1 ----------------
        rst_n = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        #12;
        check("rst_state",     {4'b0, state_dbg}, {4'b0, ST_FETCH});
        check("rst_trap",      {7'b0, trap}, 8'd0);
        check("rst_pc_en",     {7'b0, pc_en}, 8'd0);
        check("rst_ir_write",  {7'b0, ir_write}, 8'd0);
        check("rst_reg_write", {7'b0, reg_write}, 8'd0);
        check("rst_mem_write", {7'b0, mem_write}, 8'd0);
        #1 rst_n = 1'b1;
        #1;
        check("lw_c1_ir_write",  {7'b0, ir_write}, 8'd1);
        check("lw_c1_pc_en",     {7'b0, pc_en}, 8'd1);
        check("lw_c1_alu_src_b", {6'b0, alu_src_b}, 8'd1);
        check("lw_c1_reg_write", {7'b0, reg_write}, 8'd0);
        tick();
        check("lw_c2_state",     {4'b0, state_dbg}, {4'b0, ST_DECODE});
        check("lw_c2_alu_src_b", {6'b0, alu_src_b}, 8'd3);
        check("lw_c2_ir_write",  {7'b0, ir_write}, 8'd0);
        tick();
        op = 6'b000000;  // class is latched; op change must not matter
        check("lw_c3_state",     {4'b0, state_dbg}, {4'b0, ST_MEMADR});
        check("lw_c3_alu_src_a", {7'b0, alu_src_a}, 8'd1);
        check("lw_c3_alu_src_b", {6'b0, alu_src_b}, 8'd2);
        tick();
        check("lw_c4_state",     {4'b0, state_dbg}, {4'b0, ST_MEMREAD});
        check("lw_c4_iord",      {7'b0, iord}, 8'd1);
        check("lw_c4_reg_write", {7'b0, reg_write}, 8'd0);
        tick();
        check("lw_c5_state",      {4'b0, state_dbg}, {4'b0, ST_MEMWB});
        check("lw_c5_reg_write",  {7'b0, reg_write}, 8'd1);
        check("lw_c5_mem_to_reg", {7'b0, mem_to_reg}, 8'd1);
        check("lw_c5_reg_dst",    {7'b0, reg_dst}, 8'd0);
        tick();
        check("lw_end_state",     {4'b0, state_dbg}, {4'b0, ST_FETCH});
        check("lw_end_reg_write", {7'b0, reg_write}, 8'd0);

        // ---------------- SW with 3 stall cycles in MEMWRITE ----------------
        op = 6'b101011;
        tick();
        tick();
        check("sw_memadr", {4'b0, state_dbg}, {4'b0, ST_MEMADR});
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("sw_state",     {4'b0, state_dbg}, {4'b0, ST_MEMWRITE});
            check("sw_mem_write", {7'b0, mem_write}, 8'd1);
            check("sw_iord",      {7'b0, iord}, 8'd1);
            tick();
        end
        check("sw_end_state",     {4'b0, state_dbg}, {4'b0, ST_FETCH});
        check("sw_end_mem_write", {7'b0, mem_write}, 8'd0);

        // ---------------- R-type SLT ----------------
        op = 6'b000000; funct = 6'b101010;
        tick();
        tick();
        check("slt_state",     {4'b0, state_dbg}, {4'b0, ST_EXECUTE});
        check("slt_alu_ctl",   {5'b0, alu_ctl}, 8'd7);
        check("slt_alu_src_a", {7'b0, alu_src_a}, 8'd1);
        check("slt_alu_src_b", {6'b0, alu_src_b}, 8'd0);
        tick();
        check("slt_wb_state",     {4'b0, state_dbg}, {4'b0, ST_ALUWB});
        check("slt_wb_reg_write", {7'b0, reg_write}, 8'd1);
        check("slt_wb_reg_dst",   {7'b0, reg_dst}, 8'd1);
        tick();
        check("slt_end_state", {4'b0, state_dbg}, {4'b0, ST_FETCH});

        // ---------------- BNE (EXT_OPS=1 vs EXT_OPS=0) ----------------
        op = 6'b000101; funct = 6'b000000;
        tick();
        tick();
        zero = 1'b0;
        #1;
        check("bne_state",        {4'b0, state_dbg}, {4'b0, ST_BRANCH});
        check("bne_z0_pc_en",     {7'b0, pc_en}, 8'd1);
        check("bne_pc_src",       {6'b0, pc_src}, 8'd1);
        check("bne_alu_ctl",      {5'b0, alu_ctl}, 8'd6);
        check("noext_bne_state",  {4'b0, n_state_dbg}, {4'b0, ST_TRAP});
        check("noext_bne_trap",   {7'b0, n_trap}, 8'd1);
        zero = 1'b1;
        #1;
        check("bne_z1_pc_en",     {7'b0, pc_en}, 8'd0);
        tick();
        zero = 1'b0;
        check("bne_end_state", {4'b0, state_dbg}, {4'b0, ST_FETCH});

        // ---------------- ORI ----------------
        op = 6'b001101;
        tick();
        tick();
        check("ori_state",     {4'b0, state_dbg}, {4'b0, ST_IEXEC});
        check("ori_alu_ctl",   {5'b0, alu_ctl}, 8'd1);
        check("ori_imm_zext",  {7'b0, imm_zext}, 8'd1);
        check("ori_alu_src_b", {6'b0, alu_src_b}, 8'd2);
        tick();
        check("ori_wb_state",     {4'b0, state_dbg}, {4'b0, ST_IWB});
        check("ori_wb_reg_write", {7'b0, reg_write}, 8'd1);
        check("ori_wb_reg_dst",   {7'b0, reg_dst}, 8'd0);
        tick();
        check("ori_end_state", {4'b0, state_dbg}, {4'b0, ST_FETCH});

        // ---------------- J ----------------
        op = 6'b000010;
        tick();
        tick();
        check("j_state",  {4'b0, state_dbg}, {4'b0, ST_JUMP});
        check("j_pc_en",  {7'b0, pc_en}, 8'd1);
        check("j_pc_src", {6'b0, pc_src}, 8'd2);
        tick();
        check("j_end_state", {4'b0, state_dbg}, {4'b0, ST_FETCH});

        // ---------------- FETCH stall ----------------
        mem_ready = 1'b0;
        #1;
        check("fstall_ir_write", {7'b0, ir_write}, 8'd0);
        check("fstall_pc_en",    {7'b0, pc_en}, 8'd0);
        tick();
        check("fstall_state", {4'b0, state_dbg}, {4'b0, ST_FETCH});
        mem_ready = 1'b1;

        // ---------------- reset in the middle of MEMWRITE ----------------
        op = 6'b101011;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("rmw_mem_write_before", {7'b0, mem_write}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("rmw_mem_write_async", {7'b0, mem_write}, 8'd0);
        check("rmw_state_async",     {4'b0, state_dbg}, {4'b0, ST_FETCH});
        check("rmw_noext_trap_clr",  {7'b0, n_trap}, 8'd0);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rmw_after_state", {4'b0, state_dbg}, {4'b0, ST_FETCH});
        check("rmw_after_ir_write", {7'b0, ir_write}, 8'd1);

        // ---------------- illegal funct -> sticky TRAP ----------------
        op = 6'b000000; funct = 6'b000000;
        tick();
        tick();
        check("trap_state", {4'b0, state_dbg}, {4'b0, ST_TRAP});
        check("trap_flag",  {7'b0, trap}, 8'd1);
        op = 6'b100011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("trap_sticky_state", {4'b0, state_dbg}, {4'b0, ST_TRAP});
            check("trap_sticky_flag",  {7'b0, trap}, 8'd1);
            check("trap_writes", {4'b0, pc_en, ir_write, reg_write, mem_write}, 8'd0);
        end
        rst_n = 1'b0;
        #1;
        check("trap_cleared", {7'b0, trap}, 8'd0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
